mem_exception_commit: RTL and testbench
=======================================

Name: mem_exception_commit

Overview:
- MEM-stage exception commit unit, directly downstream of EXE-stage exception detection.
- Registers the EXE->MEM exception bundle, PC, address and delay-slot flag, and merges MEM-stage TLB data faults into that bundle.
- Picks the single highest-priority cause and issues one CP0 commit pulse plus a pipeline flush.
- Holds the PC redirect until the fetch unit accepts it.

Parameters:
- BEV_BASE, 32'hBFC0_0200, exception base when CP0 Status.BEV=1.
- NORM_BASE, 32'h8000_0000, exception base when BEV=0.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- EXE_Valid  in  1  EXE slot holds a real instruction
- EXE_ExceptType_final  in  ExceptinPipeType  final EXE exception vector
- EXE_PC  in  32  EXE instruction PC
- EXE_ALUOut  in  32  data virtual address
- EXE_IsInDelaySlot  in  1  EXE instruction is in a branch delay slot
- MEM_Stall  in  1  hold the MEM register
- MEM_TLBFault  in  ExceptinPipeType  only the Rd/Wr TLB data and TLBModified fields are used; all other fields are ignored
- CP0_Status_EXL  in  1  Status.EXL
- CP0_Status_BEV  in  1  Status.BEV
- CP0_EPC  in  32  eret target
- Redirect_Ready  in  1  IF accepts the redirect
- Exc_Valid  out  1  one-cycle CP0 commit strobe
- Exc_Code  out  5  ExcCode
- Exc_EPC  out  32  EPC to write
- Exc_BD  out  1  Cause.BD
- Exc_BadVAddr  out  32  BadVAddr value
- Exc_BadVAddrWr  out  1  BadVAddr write enable
- Exc_IsEret  out  1  eret commit, clears EXL
- Flush_All  out  1  flush IF..MEM
- Redirect_Valid  out  1  redirect request to IF
- Redirect_PC  out  32  redirect target

Behaviour:
- MEM register (valid, PC, ALUOut, BD, ExceptType):
  - rst or Flush_All loads zero / valid=0.
  - MEM_Stall holds the register; otherwise it loads EXE.
- Merged vector: registered ExceptType OR the TLB-data fields of MEM_TLBFault. The merged vector is masked by the registered valid.
- Priority, high to low, with ExcCode:
  - Interrupt 0
  - WrongAddressinIF 4
  - TLBRefillinIF 2
  - TLBInvalidinIF 2
  - CoprocessorUnusable 11
  - ReservedInstruction 10
  - Overflow 12
  - Trap 13
  - Syscall 8
  - Break 9
  - RdWrongAddressinMEM 4
  - WrWrongAddressinMEM 5
  - RdTLBRefill/RdTLBInvalid 2
  - WrTLBRefill/WrTLBInvalid 3
  - TLBModified 1
  - Eret (no code)
  - Refetch (no code)
- EPC = BD ? PC-4 : PC; Exc_BD = BD.
- BadVAddr:
  - IF address or IF TLB cause: PC.
  - Data address or data TLB cause: ALUOut.
  - Exc_BadVAddrWr is asserted only for these causes.
- Target:
  - Base = BEV ? BEV_BASE : NORM_BASE.
  - TLB refill causes with EXL=0: Base+0x000.
  - All other exceptions: Base+0x180.
  - Eret: CP0_EPC.
  - Refetch: PC.
- FSM IDLE/HOLD, reset to IDLE.
  - IDLE, any cause present and MEM_Stall=0: pulse Exc_Valid, or Exc_IsEret for eret. Refetch pulses neither.
  - In that same cycle: pulse Flush_All, assert Redirect_Valid, latch Redirect_PC.
  - If Redirect_Ready is also high in that cycle, stay in IDLE; else go to HOLD.
  - HOLD: Redirect_Valid held high and Redirect_PC held stable until Redirect_Ready, then return to IDLE. No new commit is taken in HOLD. The MEM register is held invalid (flush) while in HOLD.
  - Any cause present with MEM_Stall=1: no commit; the decision waits until the stall drops.
- Reset values of all outputs: 0. rst mid-HOLD drops the redirect and returns the FSM to IDLE.
- Exc_Valid and Exc_IsEret are never asserted together.

Optional Feature:
- Macro: MEM_EXC_REFETCH_EN.
- Defined: the Refetch bit causes flush and redirect to PC with no CP0 write.
- Undefined: the Refetch bit is ignored and treated as no cause.

Decomposition:
- Shared package: ExcCode localparams (EXC_INT…EXC_TR) and vector offsets (0x000, 0x180).
- Sub-module exc_priority_enc: combinational; merged vector -> {code, is_eret, is_refetch, badv_sel, is_refill}.

Test Plan:
- Overflow, PC=0x8000_1000, BD=0, EXL=0, BEV=0 -> Exc_Valid 1 cycle, Code=12, EPC=0x8000_1000, Redirect_PC=0x8000_0180, Flush_All=1.
- RdWrongAddressinMEM, ALUOut=0x1003, PC=0x8000_2004, BD=1 -> Code=4, EPC=0x8000_2000, Exc_BD=1, BadVAddr=0x1003, BadVAddrWr=1.
- MEM_TLBFault WrTLBRefill, EXL=0 -> Code=3, Redirect_PC=0x8000_0000; repeat with EXL=1 -> 0x8000_0180; BEV=1, EXL=1 -> 0xBFC0_0380.
- Syscall and Interrupt both set -> Code=0. Eret with CP0_EPC=0x8000_3000 -> Exc_IsEret=1, Exc_Valid=0, Redirect_PC=0x8000_3000.
- Redirect_Ready low for 3 cycles after a commit -> Redirect_Valid high for 4 cycles, PC stable, no second commit; assert rst in cycle 2 -> all outputs 0 next cycle.
- Refetch on PC=0x8000_4000 with macro defined -> redirect to 0x8000_4000, Exc_Valid=0; with macro undefined -> no flush, no redirect.

Source files
------------

// File: rtl/mem_exception_commit_pkg.sv
// Shared types and constants for the MEM-stage exception commit unit.
// The MEM_EXC_REFETCH_EN macro (see exc_priority_enc) enables the Refetch cause.
package mem_exception_commit_pkg;

    // Packed exception vector; the first field is the MSB.
    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefillinIF;
        logic TLBInvalidinIF;
        logic CoprocessorUnusable;
        logic ReservedInstruction;
        logic Overflow;
        logic Trap;
        logic Syscall;
        logic Break;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic RdTLBRefill;
        logic RdTLBInvalid;
        logic WrTLBRefill;
        logic WrTLBInvalid;
        logic TLBModified;
        logic Eret;
        logic Refetch;
    } ExceptinPipeType;

    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_PC   = 2'd1,
        BADV_ADDR = 2'd2
    } badv_sel_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } commit_state_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [31:0] VEC_REFILL_OFS  = 32'h0000_0000;
    localparam logic [31:0] VEC_GENERAL_OFS = 32'h0000_0180;

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder: merged exception vector -> single winning cause.
// MEM_EXC_REFETCH_EN: when defined, Refetch is reported as the lowest-priority cause.
module exc_priority_enc
    import mem_exception_commit_pkg::*;
(
    input  ExceptinPipeType i_vec,
    output logic            o_is_exc,
    output logic [4:0]      o_code,
    output logic            o_is_eret,
    output logic            o_is_refetch,
    output badv_sel_e       o_badv_sel,
    output logic            o_is_refill
);

    always_comb begin
        o_is_exc     = 1'b1;
        o_code       = EXC_INT;
        o_is_eret    = 1'b0;
        o_is_refetch = 1'b0;
        o_badv_sel   = BADV_NONE;
        o_is_refill  = 1'b0;
        if (i_vec.Interrupt) begin
            o_code = EXC_INT;
        end else if (i_vec.WrongAddressinIF) begin
            o_code = EXC_ADEL; o_badv_sel = BADV_PC;
        end else if (i_vec.TLBRefillinIF) begin
            o_code = EXC_TLBL; o_badv_sel = BADV_PC; o_is_refill = 1'b1;
        end else if (i_vec.TLBInvalidinIF) begin
            o_code = EXC_TLBL; o_badv_sel = BADV_PC;
        end else if (i_vec.CoprocessorUnusable) begin
            o_code = EXC_CPU;
        end else if (i_vec.ReservedInstruction) begin
            o_code = EXC_RI;
        end else if (i_vec.Overflow) begin
            o_code = EXC_OV;
        end else if (i_vec.Trap) begin
            o_code = EXC_TR;
        end else if (i_vec.Syscall) begin
            o_code = EXC_SYS;
        end else if (i_vec.Break) begin
            o_code = EXC_BP;
        end else if (i_vec.RdWrongAddressinMEM) begin
            o_code = EXC_ADEL; o_badv_sel = BADV_ADDR;
        end else if (i_vec.WrWrongAddressinMEM) begin
            o_code = EXC_ADES; o_badv_sel = BADV_ADDR;
        end else if (i_vec.RdTLBRefill) begin
            o_code = EXC_TLBL; o_badv_sel = BADV_ADDR; o_is_refill = 1'b1;
        end else if (i_vec.RdTLBInvalid) begin
            o_code = EXC_TLBL; o_badv_sel = BADV_ADDR;
        end else if (i_vec.WrTLBRefill) begin
            o_code = EXC_TLBS; o_badv_sel = BADV_ADDR; o_is_refill = 1'b1;
        end else if (i_vec.WrTLBInvalid) begin
            o_code = EXC_TLBS; o_badv_sel = BADV_ADDR;
        end else if (i_vec.TLBModified) begin
            o_code = EXC_MOD; o_badv_sel = BADV_ADDR;
        end else begin
            // Non-exception causes: no CP0 write, so no code.
            o_is_exc = 1'b0;
            if (i_vec.Eret) begin
                o_is_eret = 1'b1;
            end
`ifdef MEM_EXC_REFETCH_EN
            else if (i_vec.Refetch) begin
                o_is_refetch = 1'b1;
            end
`endif
        end
    end

`ifndef MEM_EXC_REFETCH_EN
    logic w_unused_refetch;
    assign w_unused_refetch = i_vec.Refetch;
`endif

endmodule

// File: rtl/mem_exception_commit.sv
// MEM-stage exception commit: registers EXE bundle, merges TLB data faults, commits one cause.
// MEM_EXC_REFETCH_EN enables the Refetch redirect (handled in exc_priority_enc).
module mem_exception_commit
    import mem_exception_commit_pkg::*;
#(
    parameter logic [31:0] BEV_BASE  = 32'hBFC0_0200,
    parameter logic [31:0] NORM_BASE = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_EXE_Valid,
    input  ExceptinPipeType i_EXE_ExceptType_final,
    input  logic [31:0]     i_EXE_PC,
    input  logic [31:0]     i_EXE_ALUOut,
    input  logic            i_EXE_IsInDelaySlot,
    input  logic            i_MEM_Stall,
    input  ExceptinPipeType i_MEM_TLBFault,
    input  logic            i_CP0_Status_EXL,
    input  logic            i_CP0_Status_BEV,
    input  logic [31:0]     i_CP0_EPC,
    input  logic            i_Redirect_Ready,
    output logic            o_Exc_Valid,
    output logic [4:0]      o_Exc_Code,
    output logic [31:0]     o_Exc_EPC,
    output logic            o_Exc_BD,
    output logic [31:0]     o_Exc_BadVAddr,
    output logic            o_Exc_BadVAddrWr,
    output logic            o_Exc_IsEret,
    output logic            o_Flush_All,
    output logic            o_Redirect_Valid,
    output logic [31:0]     o_Redirect_PC
);

    logic            r_valid;
    logic [31:0]     r_pc;
    logic [31:0]     r_alu;
    logic            r_bd;
    ExceptinPipeType r_exc;
    commit_state_e   r_state;
    commit_state_e   w_state_nxt;
    logic [31:0]     r_redir_pc;

    ExceptinPipeType w_tlb_data;
    ExceptinPipeType w_merged;
    logic            w_is_exc;
    logic [4:0]      w_code;
    logic            w_is_eret;
    logic            w_is_refetch;
    badv_sel_e       w_badv_sel;
    logic            w_is_refill;
    logic            w_commit;
    logic [31:0]     w_base;
    logic [31:0]     w_target;

    // Only the data-side TLB faults are taken from the MMU port.
    always_comb begin
        w_tlb_data              = '0;
        w_tlb_data.RdTLBRefill  = i_MEM_TLBFault.RdTLBRefill;
        w_tlb_data.RdTLBInvalid = i_MEM_TLBFault.RdTLBInvalid;
        w_tlb_data.WrTLBRefill  = i_MEM_TLBFault.WrTLBRefill;
        w_tlb_data.WrTLBInvalid = i_MEM_TLBFault.WrTLBInvalid;
        w_tlb_data.TLBModified  = i_MEM_TLBFault.TLBModified;
    end

    logic w_unused_tlb;
    assign w_unused_tlb = ^{i_MEM_TLBFault[18:7], i_MEM_TLBFault[1:0]};

    assign w_merged = r_valid ? (r_exc | w_tlb_data) : '0;

    exc_priority_enc u_prio (
        .i_vec        (w_merged),
        .o_is_exc     (w_is_exc),
        .o_code       (w_code),
        .o_is_eret    (w_is_eret),
        .o_is_refetch (w_is_refetch),
        .o_badv_sel   (w_badv_sel),
        .o_is_refill  (w_is_refill)
    );

    assign w_commit = (r_state == S_IDLE) && !i_MEM_Stall
                      && (w_is_exc || w_is_eret || w_is_refetch);
    assign w_base   = i_CP0_Status_BEV ? BEV_BASE : NORM_BASE;

    always_comb begin
        if (w_is_eret)
            w_target = i_CP0_EPC;
        else if (w_is_refetch)
            w_target = r_pc;
        else if (w_is_refill && !i_CP0_Status_EXL)
            w_target = w_base + VEC_REFILL_OFS;
        else
            w_target = w_base + VEC_GENERAL_OFS;
    end

    always_comb begin
        w_state_nxt      = r_state;
        o_Exc_Valid      = 1'b0;
        o_Exc_Code       = 5'd0;
        o_Exc_EPC        = 32'd0;
        o_Exc_BD         = 1'b0;
        o_Exc_BadVAddr   = 32'd0;
        o_Exc_BadVAddrWr = 1'b0;
        o_Exc_IsEret     = 1'b0;
        o_Flush_All      = 1'b0;
        o_Redirect_Valid = 1'b0;
        o_Redirect_PC    = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    o_Exc_Valid      = w_is_exc;
                    o_Exc_IsEret     = w_is_eret;
                    o_Flush_All      = 1'b1;
                    o_Redirect_Valid = 1'b1;
                    o_Redirect_PC    = w_target;
                    if (w_is_exc) begin
                        o_Exc_Code       = w_code;
                        o_Exc_EPC        = r_bd ? (r_pc - 32'd4) : r_pc;
                        o_Exc_BD         = r_bd;
                        o_Exc_BadVAddrWr = (w_badv_sel != BADV_NONE);
                        o_Exc_BadVAddr   = (w_badv_sel == BADV_PC)   ? r_pc  :
                                           (w_badv_sel == BADV_ADDR) ? r_alu : 32'd0;
                    end
                    if (!i_Redirect_Ready)
                        w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                o_Redirect_Valid = 1'b1;
                o_Redirect_PC    = r_redir_pc;
                if (i_Redirect_Ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_redir_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_commit)
                r_redir_pc <= w_target;
        end
    end

    // HOLD keeps the slot empty so nothing behind the redirect can commit.
    always_ff @(posedge i_clk) begin
        if (i_rst || o_Flush_All || (r_state == S_HOLD)) begin
            r_valid <= 1'b0;
            r_pc    <= 32'd0;
            r_alu   <= 32'd0;
            r_bd    <= 1'b0;
            r_exc   <= '0;
        end else if (!i_MEM_Stall) begin
            r_valid <= i_EXE_Valid;
            r_pc    <= i_EXE_PC;
            r_alu   <= i_EXE_ALUOut;
            r_bd    <= i_EXE_IsInDelaySlot;
            r_exc   <= i_EXE_ExceptType_final;
        end
    end

endmodule

// File: tb/tb_mem_exception_commit.sv
// Directed bench for mem_exception_commit with a cause-table reference model.
module tb_mem_exception_commit;
    import mem_exception_commit_pkg::*;

    // Bit positions in the 19-bit exception vector (MSB = Interrupt).
    localparam int B_INT = 18, B_TR = 11, B_OV = 12, B_SYS = 10, B_BP = 9;
    localparam int B_RDWA = 8, B_WRREF = 4, B_ERET = 1, B_REFETCH = 0;
    localparam logic [18:0] TLB_MASK = 19'h0007C;

    logic        clk, rst;
    logic        exe_valid, exe_bd, stall, exl, bev, ready;
    logic [31:0] exe_pc, exe_alu, cp0_epc;
    logic [18:0] exe_exc, tlb_f;
    ExceptinPipeType exe_exc_s, tlb_s;
    assign exe_exc_s = exe_exc;
    assign tlb_s     = tlb_f;

    logic        o_ev, o_bd, o_bwr, o_eret, o_flush, o_rv;
    logic [4:0]  o_code;
    logic [31:0] o_epc, o_badv, o_rpc;

    mem_exception_commit dut (
        .i_clk(clk), .i_rst(rst), .i_EXE_Valid(exe_valid),
        .i_EXE_ExceptType_final(exe_exc_s), .i_EXE_PC(exe_pc),
        .i_EXE_ALUOut(exe_alu), .i_EXE_IsInDelaySlot(exe_bd),
        .i_MEM_Stall(stall), .i_MEM_TLBFault(tlb_s),
        .i_CP0_Status_EXL(exl), .i_CP0_Status_BEV(bev), .i_CP0_EPC(cp0_epc),
        .i_Redirect_Ready(ready),
        .o_Exc_Valid(o_ev), .o_Exc_Code(o_code), .o_Exc_EPC(o_epc),
        .o_Exc_BD(o_bd), .o_Exc_BadVAddr(o_badv), .o_Exc_BadVAddrWr(o_bwr),
        .o_Exc_IsEret(o_eret), .o_Flush_All(o_flush),
        .o_Redirect_Valid(o_rv), .o_Redirect_PC(o_rpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        commit, ev, bd, bwr, eret, flush, rv;
        logic [4:0]  code;
        logic [31:0] epc, badv, rpc;
    } exp_t;

    logic        m_valid = 1'b0, m_bd = 1'b0, m_hold = 1'b0;
    logic [31:0] m_pc = '0, m_alu = '0, m_hpc = '0;
    logic [18:0] m_exc = '0;

    function automatic logic [4:0] code_of(input int b);
        case (b)
            18: return 5'd0;  17: return 5'd4;  16: return 5'd2;  15: return 5'd2;
            14: return 5'd11; 13: return 5'd10; 12: return 5'd12; 11: return 5'd13;
            10: return 5'd8;  9:  return 5'd9;  8:  return 5'd4;  7:  return 5'd5;
            6:  return 5'd2;  5:  return 5'd2;  4:  return 5'd3;  3:  return 5'd3;
            default: return 5'd1;
        endcase
    endfunction

    function automatic exp_t model_eval();
        exp_t e;
        logic [18:0] v;
        logic [31:0] base, tgt;
        int hit;
        bit refetch_en;
        e = '0;
        tgt = '0;
`ifdef MEM_EXC_REFETCH_EN
        refetch_en = 1'b1;
`else
        refetch_en = 1'b0;
`endif
        if (m_hold) begin
            e.rv = 1'b1; e.rpc = m_hpc;
            return e;
        end
        v = m_valid ? (m_exc | (tlb_f & TLB_MASK)) : '0;
        hit = -1;
        for (int b = 18; b >= 2; b--)
            if (v[b] && hit < 0) hit = b;
        base = bev ? 32'hBFC0_0200 : 32'h8000_0000;
        if (hit >= 0) begin
            e.ev = 1'b1; e.code = code_of(hit);
            e.epc = m_bd ? m_pc - 32'd4 : m_pc; e.bd = m_bd;
            if (hit >= 15 && hit <= 17) begin e.bwr = 1'b1; e.badv = m_pc; end
            if (hit <= 8)               begin e.bwr = 1'b1; e.badv = m_alu; end
            tgt = ((hit == 16 || hit == 6 || hit == 4) && !exl) ? base : base + 32'h180;
        end else if (v[1]) begin
            e.eret = 1'b1; tgt = cp0_epc;
        end else if (v[0] && refetch_en) begin
            tgt = m_pc;
        end else begin
            return e;
        end
        if (stall) return '0;
        e.commit = 1'b1; e.flush = 1'b1; e.rv = 1'b1; e.rpc = tgt;
        return e;
    endfunction

    // Model state advance on each active edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        e = model_eval();
        if (rst) begin
            m_valid = 0; m_pc = 0; m_alu = 0; m_bd = 0; m_exc = 0; m_hold = 0; m_hpc = 0;
        end else if (m_hold || e.commit) begin
            if (m_hold) m_hold = !ready;
            else if (!ready) begin m_hold = 1'b1; m_hpc = e.rpc; end
            m_valid = 0; m_pc = 0; m_alu = 0; m_bd = 0; m_exc = 0;
        end else if (!stall) begin
            m_valid = exe_valid; m_pc = exe_pc; m_alu = exe_alu; m_bd = exe_bd; m_exc = exe_exc;
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        exp_t ce;
        @(negedge clk);
        if (en) begin
            ce = model_eval();
            chk("m_Exc_Valid",    32'(o_ev),    32'(ce.ev));
            chk("m_Exc_Code",     32'(o_code),  32'(ce.code));
            chk("m_Exc_EPC",      o_epc,        ce.epc);
            chk("m_Exc_BD",       32'(o_bd),    32'(ce.bd));
            chk("m_BadVAddr",     o_badv,       ce.badv);
            chk("m_BadVAddrWr",   32'(o_bwr),   32'(ce.bwr));
            chk("m_IsEret",       32'(o_eret),  32'(ce.eret));
            chk("m_Flush_All",    32'(o_flush), 32'(ce.flush));
            chk("m_Redirect_Vld", 32'(o_rv),    32'(ce.rv));
            chk("m_Redirect_PC",  o_rpc,        ce.rpc);
            chk("m_excl_eret",    32'(o_ev & o_eret), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu,
                         input logic bd, input logic [18:0] exc);
        @(posedge clk); #1;
        exe_valid = 1'b1; exe_pc = pc; exe_alu = alu; exe_bd = bd; exe_exc = exc;
        @(posedge clk); #1;
        exe_valid = 1'b0; exe_pc = '0; exe_alu = '0; exe_bd = 1'b0; exe_exc = '0;
        @(negedge clk);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    function automatic logic [18:0] bitv(input int b);
        logic [18:0] one;
        one = 19'd1;
        return one << b;
    endfunction

    initial begin
        rst = 1'b1; exe_valid = 0; exe_bd = 0; stall = 0; exl = 0; bev = 0; ready = 1;
        exe_pc = '0; exe_alu = '0; cp0_epc = '0; exe_exc = '0; tlb_f = '0;
        @(posedge clk); #1; en = 1'b1;
        @(negedge clk);
        chk("rst_Exc_Valid", 32'(o_ev), 32'd0);
        chk("rst_Redirect",  32'(o_rv), 32'd0);
        chk("rst_RPC",       o_rpc, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Overflow, general vector
        issue(32'h8000_1000, 32'h0, 1'b0, bitv(B_OV));
        chk("ov_valid", 32'(o_ev), 32'd1);
        chk("ov_code",  32'(o_code), 32'd12);
        chk("ov_epc",   o_epc, 32'h8000_1000);
        chk("ov_rpc",   o_rpc, 32'h8000_0180);
        chk("ov_flush", 32'(o_flush), 32'd1);
        settle(); @(negedge clk);
        chk("ov_one_cycle", 32'(o_ev), 32'd0);

        // Data address error in a delay slot
        issue(32'h8000_2004, 32'h0000_1003, 1'b1, bitv(B_RDWA));
        chk("ade_code", 32'(o_code), 32'd4);
        chk("ade_epc",  o_epc, 32'h8000_2000);
        chk("ade_bd",   32'(o_bd), 32'd1);
        chk("ade_badv", o_badv, 32'h0000_1003);
        chk("ade_bwr",  32'(o_bwr), 32'd1);
        settle();

        // Write TLB refill from the MMU port: EXL / BEV vector variants
        tlb_f = bitv(B_WRREF);
        issue(32'h8000_7000, 32'h0000_2000, 1'b0, '0);
        chk("tlbs_code", 32'(o_code), 32'd3);
        chk("tlbs_rpc_refill", o_rpc, 32'h8000_0000);
        settle(); exl = 1'b1;
        issue(32'h8000_7000, 32'h0000_2000, 1'b0, '0);
        chk("tlbs_rpc_exl", o_rpc, 32'h8000_0180);
        settle(); bev = 1'b1;
        issue(32'h8000_7000, 32'h0000_2000, 1'b0, '0);
        chk("tlbs_rpc_bev", o_rpc, 32'hBFC0_0380);
        settle(); tlb_f = '0; bev = 1'b0; exl = 1'b0;

        // Interrupt beats syscall
        issue(32'h8000_8000, 32'h0, 1'b0, bitv(B_SYS) | bitv(B_INT));
        chk("int_code", 32'(o_code), 32'd0);
        chk("int_valid", 32'(o_ev), 32'd1);
        settle();

        // Eret
        cp0_epc = 32'h8000_3000;
        issue(32'h8000_9000, 32'h0, 1'b0, bitv(B_ERET));
        chk("eret_flag",  32'(o_eret), 32'd1);
        chk("eret_valid", 32'(o_ev), 32'd0);
        chk("eret_rpc",   o_rpc, 32'h8000_3000);
        settle();

        // Redirect held for 4 cycles while IF is not ready
        ready = 1'b0;
        issue(32'h8000_5000, 32'h0, 1'b0, bitv(B_BP));
        chk("hold_c0_valid", 32'(o_ev), 32'd1);
        chk("hold_c0_code",  32'(o_code), 32'd9);
        settle();
        exe_valid = 1'b1; exe_pc = 32'h8000_5004; exe_exc = bitv(B_SYS);
        @(negedge clk);
        chk("hold_c1_rv",  32'(o_rv), 32'd1);
        chk("hold_c1_rpc", o_rpc, 32'h8000_0180);
        chk("hold_c1_ev",  32'(o_ev), 32'd0);
        settle(); @(negedge clk);
        chk("hold_c2_rv",  32'(o_rv), 32'd1);
        chk("hold_c2_ev",  32'(o_ev), 32'd0);
        settle();
        ready = 1'b1; exe_valid = 1'b0; exe_pc = '0; exe_exc = '0;
        @(negedge clk);
        chk("hold_c3_rv",  32'(o_rv), 32'd1);
        chk("hold_c3_rpc", o_rpc, 32'h8000_0180);
        settle(); @(negedge clk);
        chk("hold_c4_rv", 32'(o_rv), 32'd0);
        chk("hold_c4_ev", 32'(o_ev), 32'd0);

        // Reset while holding the redirect
        ready = 1'b0;
        issue(32'h8000_A000, 32'h0, 1'b0, bitv(B_TR));
        chk("rsth_code", 32'(o_code), 32'd13);
        settle();
        settle(); rst = 1'b1;
        settle(); rst = 1'b0;
        @(negedge clk);
        chk("rsth_rv",    32'(o_rv), 32'd0);
        chk("rsth_rpc",   o_rpc, 32'd0);
        chk("rsth_flush", 32'(o_flush), 32'd0);
        ready = 1'b1;

        // Stall defers the commit
        settle();
        exe_valid = 1'b1; exe_pc = 32'h8000_6000; exe_exc = bitv(B_OV);
        settle();
        exe_valid = 1'b0; exe_pc = '0; exe_exc = '0; stall = 1'b1;
        @(negedge clk);
        chk("stall_ev",    32'(o_ev), 32'd0);
        chk("stall_flush", 32'(o_flush), 32'd0);
        settle(); stall = 1'b0;
        @(negedge clk);
        chk("unstall_ev",  32'(o_ev), 32'd1);
        chk("unstall_epc", o_epc, 32'h8000_6000);
        settle();

        // Refetch
        issue(32'h8000_4000, 32'h0, 1'b0, bitv(B_REFETCH));
        chk("refetch_ev", 32'(o_ev), 32'd0);
`ifdef MEM_EXC_REFETCH_EN
        chk("refetch_rv",  32'(o_rv), 32'd1);
        chk("refetch_rpc", o_rpc, 32'h8000_4000);
`else
        chk("refetch_rv",    32'(o_rv), 32'd0);
        chk("refetch_flush", 32'(o_flush), 32'd0);
`endif
        settle(); settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
